// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared defaults and helpers for the multi-channel clock
//               divider: default counter width, reset divisor, channel-select
//               width and the minimum-divisor clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

   // Default counter / divisor width in bits.
   localparam int CNT_W_DEF   = 27;
   // Divisor loaded into every channel at reset.
   localparam int DIV_RST_DEF = 4;
   // Widest counter the clamp helper supports.
   localparam int MAX_CNT_W   = 64;

   // Smallest usable period: a divide-by-1 or divide-by-0 has no low phase.
   localparam logic [MAX_CNT_W-1:0] C_MIN_DIV = MAX_CNT_W'(2);

   // Channel-select width, never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Effective divisor: 0 and 1 behave as 2.
   function automatic logic [MAX_CNT_W-1:0] clamp_div(input logic [MAX_CNT_W-1:0] d);
      return (d < C_MIN_DIV) ? C_MIN_DIV : d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multi_clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider_if
// Description : Control / status bundle of the multi-channel clock divider.
//               master = controller side, slave = divider side.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_clock_divider_if
   import clkdiv_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int CNT_W = CNT_W_DEF
);
   localparam int CH_W = ch_width(N_CH);

   logic [N_CH-1:0]  en;
   logic             sync;
   logic             div_wr;
   logic [CH_W-1:0]  div_sel;
   logic [CNT_W-1:0] div_val;
   logic [N_CH-1:0]  Clk_Out;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  pend;

   modport master (
      output en, sync, div_wr, div_sel, div_val,
      input  Clk_Out, tick, pend
   );

   modport slave (
      input  en, sync, div_wr, div_sel, div_val,
      output Clk_Out, tick, pend
   );

endinterface
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_channel
// Description : One divider channel: period counter, active and shadow
//               divisor, registered divided clock and period-start tick.
//               A new divisor only takes effect at a period boundary or
//               while the channel is idle, so the output never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
)(
   input  wire logic             Clk_In,
   input  wire logic             RST,
   input  wire logic             en,
   input  wire logic             sync,
   input  wire logic             wr,
   input  wire logic [CNT_W-1:0] wr_val,
   output      logic             Clk_Out,
   output      logic             tick,
   output      logic             pend
);

   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_DIV_INIT = CNT_W'(DIV_RST);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pdiv;
   logic             r_pend;
   logic             r_en_q;
   logic             r_clk_out;
   logic             r_tick;

   logic [CNT_W-1:0] w_deff;
   logic [CNT_W-1:0] w_half;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_restart;
   logic             w_apply;

   // Next count and restart/apply decisions for the current period.
   always_comb begin
      w_deff     = CNT_W'(clamp_div(MAX_CNT_W'(r_div)));
      // ceil(D_eff/2) without risking overflow of D_eff+1
      w_half     = (w_deff >> 1) + {{(CNT_W-1){1'b0}}, w_deff[0]};
      // A fresh enable, a sync or the end of the period all restart at 0;
      // a sync landing on the wrap edge is still a single restart.
      w_restart  = (en & ~r_en_q) | sync | (r_cnt >= (w_deff - C_ONE));
      w_cnt_next = w_restart ? '0 : (r_cnt + C_ONE);
      // Divisor changes are safe at a period start or while idle.
      w_apply    = ~en | w_restart;
   end

   // Counter and registered outputs; an idle channel holds everything low.
   always_ff @(posedge Clk_In or negedge RST) begin
      if (!RST) begin
         r_en_q    <= 1'b0;
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_en_q <= en;
         if (en) begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= (w_cnt_next < w_half);
            r_tick    <= w_restart;
         end else begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
         end
      end
   end

   // Shadow divisor: hold a write until the next safe edge; a write on that
   // edge goes straight to the active divisor.
   always_ff @(posedge Clk_In or negedge RST) begin
      if (!RST) begin
         r_div  <= C_DIV_INIT;
         r_pdiv <= C_DIV_INIT;
         r_pend <= 1'b0;
      end else if (w_apply) begin
         if (wr) begin
            r_div  <= wr_val;
            r_pdiv <= wr_val;
         end else if (r_pend) begin
            r_div  <= r_pdiv;
         end
         r_pend <= 1'b0;
      end else if (wr) begin
         r_pdiv <= wr_val;
         r_pend <= 1'b1;
      end
   end

   assign Clk_Out = r_clk_out;
   assign tick    = r_tick;
   assign pend    = r_pend;

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_clock_divider
// Description : N_CH independent clock dividers sharing one input clock.
//               Decodes divisor writes to one channel and fans sync out to
//               all of them; all timing logic lives in clkdiv_channel.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
)(
   input wire logic              Clk_In,
   input wire logic              RST,
   multi_clock_divider_if.slave  bus
);

   localparam int CH_W = ch_width(N_CH);

   logic            w_sel_ok;
   logic [N_CH-1:0] w_wr;
   logic [N_CH-1:0] w_clk_out;
   logic [N_CH-1:0] w_tick;
   logic [N_CH-1:0] w_pend;

   // Writes addressed beyond the last channel are dropped.
   assign w_sel_ok = (32'(bus.div_sel) < 32'(N_CH));

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         assign w_wr[i] = bus.div_wr & w_sel_ok & (32'(bus.div_sel) == 32'(i));

         clkdiv_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
         ) u_channel (
            .Clk_In  (Clk_In),
            .RST     (RST),
            .en      (bus.en[i]),
            .sync    (bus.sync),
            .wr      (w_wr[i]),
            .wr_val  (bus.div_val),
            .Clk_Out (w_clk_out[i]),
            .tick    (w_tick[i]),
            .pend    (w_pend[i])
         );
      end
   endgenerate

   assign bus.Clk_Out = w_clk_out;
   assign bus.tick    = w_tick;
   assign bus.pend    = w_pend;

   // Keeps the select width visibly tied to the interface it decodes.
   logic [CH_W-1:0] w_sel_unused;
   assign w_sel_unused = bus.div_sel;

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_clock_divider
// Description : Directed self-checking bench for multi_clock_divider with
//               three channels; expected waveforms are hand-computed bit
//               strings, first sample in the MSB position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_clock_divider;

   localparam int N_CH  = 3;
   localparam int CNT_W = 27;

   logic Clk_In;
   logic RST;

   int n_checks;
   int n_errs;

   logic [31:0] cap_clk  [N_CH];
   logic [31:0] cap_tick [N_CH];
   logic [31:0] cap_pend [N_CH];

   multi_clock_divider_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   multi_clock_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_RST(4)) dut (
      .Clk_In (Clk_In),
      .RST    (RST),
      .bus    (bus)
   );

   // 10 ns clock
   initial begin
      Clk_In = 1'b0;
      forever #5 Clk_In = ~Clk_In;
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge Clk_In);
      #1;
   endtask

   // Record n cycles of every channel's outputs, first sample in the MSB.
   task automatic capture(input int n);
      for (int c = 0; c < N_CH; c++) begin
         cap_clk[c]  = '0;
         cap_tick[c] = '0;
         cap_pend[c] = '0;
      end
      for (int k = 0; k < n; k++) begin
         step();
         for (int c = 0; c < N_CH; c++) begin
            cap_clk[c]  = {cap_clk[c][30:0],  bus.Clk_Out[c]};
            cap_tick[c] = {cap_tick[c][30:0], bus.tick[c]};
            cap_pend[c] = {cap_pend[c][30:0], bus.pend[c]};
         end
      end
   endtask

   // Write a divisor to a disabled ch0 and enable it again next cycle.
   task automatic load_ch0(input logic [CNT_W-1:0] val);
      bus.en      = '0;
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd0;
      bus.div_val = val;
      step();
      bus.div_wr  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks    = 0;
      n_errs      = 0;
      RST         = 1'b0;
      bus.en      = '0;
      bus.sync    = 1'b0;
      bus.div_wr  = 1'b0;
      bus.div_sel = '0;
      bus.div_val = '0;

      // Reset state
      #23;
      chk_val("rst_clk",  32'(bus.Clk_Out), 32'h0);
      chk_val("rst_tick", 32'(bus.tick),    32'h0);
      chk_val("rst_pend", 32'(bus.pend),    32'h0);
      step();
      RST = 1'b1;
      step();

      // Reset divisor 4: 1100 repeating, tick on each rising edge
      bus.en = 3'b001;
      capture(8);
      chk_val("d4_clk",  cap_clk[0],  32'hCC);
      chk_val("d4_tick", cap_tick[0], 32'h88);
      chk_val("d4_ch1_idle", cap_clk[1], 32'h0);

      // Divisor 5: 11100 repeating; write while idle applies at once
      load_ch0(27'd5);
      chk_val("d5_pend_idle", 32'(bus.pend[0]), 32'h0);
      bus.en = 3'b001;
      capture(10);
      chk_val("d5_clk",  cap_clk[0],  32'h39C);
      chk_val("d5_tick", cap_tick[0], 32'h210);

      // Divisors 1 and 0 both clamp to 2
      load_ch0(27'd1);
      bus.en = 3'b001;
      capture(4);
      chk_val("d1_clk",  cap_clk[0],  32'hA);
      chk_val("d1_tick", cap_tick[0], 32'hA);
      load_ch0(27'd0);
      bus.en = 3'b001;
      capture(4);
      chk_val("d0_clk",  cap_clk[0],  32'hA);

      // Write 8 at cnt=1 of a period-4 run: old period finishes first
      load_ch0(27'd4);
      bus.en = 3'b001;
      step();                   // cnt 0
      step();                   // cnt 1
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd0;
      bus.div_val = 27'd8;
      step();                   // cnt 2
      bus.div_wr  = 1'b0;
      chk_val("d8_pend_set", 32'(bus.pend[0]),    32'h1);
      chk_val("d8_clk_mid",  32'(bus.Clk_Out[0]), 32'h0);
      capture(10);              // cnt 3, then 0..7, then 0
      chk_val("d8_clk",  cap_clk[0],  32'h1E1);
      chk_val("d8_pend", cap_pend[0], 32'h200);
      chk_val("d8_tick", cap_tick[0], 32'h101);

      // Two channels, periods 3 and 6, sync mid-period
      bus.en      = '0;
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd0;
      bus.div_val = 27'd3;
      step();
      bus.div_sel = 2'd1;
      bus.div_val = 27'd6;
      step();
      bus.div_wr  = 1'b0;
      bus.en      = 3'b011;
      step();                   // both cnt 0
      step();                   // both cnt 1
      bus.sync = 1'b1;
      step();                   // both restart
      bus.sync = 1'b0;
      chk_val("sync_tick", 32'(bus.tick), 32'h3);
      capture(6);
      chk_val("sync_ch0_tick", cap_tick[0], 32'h09);
      chk_val("sync_ch0_clk",  cap_clk[0],  32'h2D);
      chk_val("sync_ch1_tick", cap_tick[1], 32'h01);
      chk_val("sync_ch1_clk",  cap_clk[1],  32'h31);

      // Sync landing on ch0's wrap edge: one restart, one tick
      step();                   // ch0 cnt 1
      step();                   // ch0 cnt 2
      bus.sync = 1'b1;
      step();
      bus.sync = 1'b0;
      chk_val("sync_wrap_tick", 32'(bus.tick[0]), 32'h1);
      capture(3);
      chk_val("sync_wrap_clk",  cap_clk[0],  32'h5);
      chk_val("sync_wrap_tk3",  cap_tick[0], 32'h1);

      // Write on the applying edge bypasses straight to the active divisor
      step();                   // ch0 cnt 1
      step();                   // ch0 cnt 2
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd0;
      bus.div_val = 27'd5;
      step();                   // wrap, new divisor 5
      bus.div_wr  = 1'b0;
      chk_val("bypass_pend", 32'(bus.pend[0]), 32'h0);
      chk_val("bypass_tick", 32'(bus.tick[0]), 32'h1);
      capture(5);
      chk_val("bypass_clk",  cap_clk[0],  32'h19);
      chk_val("bypass_tk5",  cap_tick[0], 32'h01);

      // Reset mid-period clears outputs without a clock edge
      chk_val("pre_rst_clk", 32'(bus.Clk_Out[0]), 32'h1);
      RST = 1'b0;
      #2;
      chk_val("async_rst_clk",  32'(bus.Clk_Out), 32'h0);
      chk_val("async_rst_tick", 32'(bus.tick),    32'h0);
      chk_val("async_rst_pend", 32'(bus.pend),    32'h0);
      step();
      step();

      // Release: divisor back to 4, out-of-range write ignored
      RST         = 1'b1;
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd3;
      bus.div_val = 27'd7;
      step();
      bus.div_wr  = 1'b0;
      chk_val("post_rst_clk",  32'(bus.Clk_Out[0]), 32'h1);
      chk_val("post_rst_tick", 32'(bus.tick[0]),    32'h1);
      chk_val("bad_sel_pend",  32'(bus.pend),       32'h0);
      capture(7);
      chk_val("post_rst_ch0", cap_clk[0], 32'h4C);
      chk_val("post_rst_ch1", cap_clk[1], 32'h4C);
      chk_val("post_rst_tk0", cap_tick[0], 32'h08);
      chk_val("post_rst_ch2", cap_clk[2], 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_clock_divider.md
MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

Interface
REQ-001 Parameter N_CH, default 2: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 27: counter and divisor width in bits.
REQ-003 Parameter DIV_RST, default 4: divisor loaded into every channel at reset.
REQ-004 Localparam CH_W = max(1, clog2(N_CH)): channel-select width.
REQ-005 Clk_In  in  1  sole clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, asynchronous assert, active-low.
REQ-007 en  in  N_CH  per-channel run enable, level-sensitive.
REQ-008 sync  in  1  one-cycle pulse; restarts all enabled channels at count 0.
REQ-009 div_wr  in  1  divisor write strobe, one cycle per write.
REQ-010 div_sel  in  CH_W  target channel for div_wr.
REQ-011 div_val  in  CNT_W  requested period in Clk_In cycles.
REQ-012 Clk_Out  out  N_CH  registered divided clock per channel.
REQ-013 tick  out  N_CH  registered one-cycle pulse at each period start.
REQ-014 pend  out  N_CH  high while a written divisor awaits application.

Function
REQ-015 Each channel holds cnt (CNT_W), active divisor D, pending divisor P and pending flag.
REQ-016 Effective divisor: D_eff = max(D, 2); values 0 and 1 clamp to 2.
REQ-017 Enabled channel: cnt_next = 0 if (cnt >= D_eff-1 or sync), else cnt+1.
REQ-018 Clk_Out[i] <= en[i] and (cnt_next < ceil(D_eff/2)); exact 50% duty for even D_eff, high one extra cycle for odd.
REQ-019 tick[i] <= en[i] and (cnt_next == 0); exactly one pulse per period.
REQ-020 Disabled channel: cnt <= 0, Clk_Out[i] <= 0, tick[i] <= 0.
REQ-021 en[i] rising at edge k: cnt = 0, Clk_Out = 1 and tick = 1 after edge k.
REQ-022 div_wr with div_sel < N_CH: P <= div_val, pend set; div_sel >= N_CH is ignored.
REQ-023 Pending divisor applies (D <= P, pend cleared) only at the edge where cnt_next == 0 (wrap, sync or enable) or while the channel is disabled; no glitch mid-period.
REQ-024 div_wr coincident with the applying edge: div_val bypasses to D at that edge and pend stays clear.
REQ-025 A second div_wr before application overwrites P; the last write wins.
REQ-026 sync coincident with wrap: a single restart and a single tick.
REQ-027 Arithmetic is unsigned CNT_W; the counter never exceeds D_eff-1 and never wraps through 2^CNT_W.
REQ-028 Output latency: one Clk_In cycle from cnt_next to Clk_Out and tick; channels are mutually independent except for sync.

Reset
REQ-029 While RST = 0, all flops clear asynchronously: cnt = 0, D = DIV_RST, P = DIV_RST, pend = 0, Clk_Out = 0, tick = 0.
REQ-030 RST asserted mid-period aborts the period immediately; after release, operation resumes per en with a fresh count from 0.

Structure
REQ-031 Package clkdiv_pkg holds CNT_W default, DIV_RST default and the clamp function for minimum divisor 2.
REQ-032 One sub-module, clkdiv_channel (counter, shadow divisor, output flops), is instantiated N_CH times by generate; the top holds only write decode and sync fan-out.

Verification
REQ-033 D = 4, en[0] = 1: Clk_Out[0] = 1100 repeating; tick[0] every 4th cycle, coincident with the rising edge.
REQ-034 D = 5: Clk_Out = 11100 repeating; D = 0 and D = 1 each behave as D = 2, giving 10 repeating.
REQ-035 Write D = 8 at cnt = 1 of a D = 4 period: pend = 1 for 2 cycles, old period completes, next period is 8 with no truncated pulse.
REQ-036 Two channels with D = 3 and 6, sync pulsed mid-period: both tick the cycle after sync; a sync coincident with wrap yields one tick.
REQ-037 RST low mid-period: outputs go 0 without a clock edge; after release, D reverts to DIV_RST = 4 and a write to div_sel = N_CH has no effect.
